// File: rtl/pipeline_types.sv
// Shared types for the single-wire receive pipeline.
// Holds the edge-strobe bundle produced by the timer stage, the decoder
// state encoding and the default word size used by the decoder.
package pipeline_types;

    localparam int DATA_BITS_DEFAULT = 24;

    // One-cycle strobes marking line transitions detected by the timer stage.
    typedef struct packed {
        logic rising;
        logic falling;
    } edges_t;

    // Decoder FSM encoding (2 bits, fixed values so logs stay comparable).
    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } decoder_state_t;

endpackage

// File: rtl/pulse_classifier.sv
// Combinational high-time classifier.
// Maps a measured high time onto a data bit plus runt/overlong flags.
// The bit output is only meaningful when neither flag is set.
module pulse_classifier
    import pipeline_types::*;
#(
    parameter int WIDTH       = 12,
    parameter int BIT1_THRESH = 30,
    parameter int MIN_HIGH    = 8,
    parameter int MAX_HIGH    = 60
) (
    input  logic [WIDTH-1:0] i_high_time,
    output logic             o_bit,
    output logic             o_runt,
    output logic             o_overlong
);

    localparam logic [WIDTH-1:0] LP_BIT1_THRESH = WIDTH'(BIT1_THRESH);
    localparam logic [WIDTH-1:0] LP_MIN_HIGH    = WIDTH'(MIN_HIGH);
    localparam logic [WIDTH-1:0] LP_MAX_HIGH    = WIDTH'(MAX_HIGH);

    // Threshold compares; boundaries are inclusive on the '1' and legal sides.
    always_comb begin
        o_bit      = (i_high_time >= LP_BIT1_THRESH);
        o_runt     = (i_high_time <  LP_MIN_HIGH);
        o_overlong = (i_high_time >  LP_MAX_HIGH);
    end

endmodule

// File: rtl/pulse_decoder.sv
// Pulse-width decoder for the single-wire receive pipeline.
// Classifies high pulses into bits, shifts them MSB-first into a word,
// hands completed words downstream on valid/ready and reports frame-reset gaps.
// Optional feature: define PULSE_DECODER_ERRCNT_EN to build the saturating
// runt/overlong counter on o_err_count; otherwise o_err_count is tied to 0.
//
// state  | meaning
// S_SYNC | after reset, waiting for the first long low gap (no frame_end)
// S_IDLE | synchronised, line low, waiting for the first pulse of a frame
// S_HIGH | line high, measuring a pulse
// S_LOW  | line low between pulses, watching for the frame-reset gap
module pulse_decoder
    import pipeline_types::*;
#(
    parameter int WIDTH        = 12,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int BIT1_THRESH  = 30,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 60,
    parameter int RESET_CYCLES = 2500
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  edges_t               i_edges,
    input  logic [WIDTH-1:0]     i_timer_value,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic                 o_frame_end,
    output logic                 o_overflow,
    output logic [15:0]          o_err_count
);

    localparam int               CW           = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]    LP_LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic [WIDTH-1:0] LP_RESET_GAP = WIDTH'(RESET_CYCLES);

    decoder_state_t         r_state;
    decoder_state_t         w_state_nxt;
    logic                   r_line_high;
    logic [DATA_BITS-2:0]   r_shift;
    logic [CW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_data_valid;
    logic                   r_frame_end;
    logic                   r_overflow;

    logic                   w_rise;
    logic                   w_fall;
    logic                   w_any_edge;
    logic                   w_gap;
    logic                   w_bit;
    logic                   w_runt;
    logic                   w_overlong;
    logic                   w_take_bit;
    logic                   w_frame_end_nxt;
    logic                   w_load;
    logic                   w_accept;
    logic [DATA_BITS-1:0]   w_word;

    // Rising wins if upstream ever strobes both edges in one cycle.
    assign w_rise     = i_edges.rising;
    assign w_fall     = i_edges.falling & ~i_edges.rising;
    assign w_any_edge = i_edges.rising | i_edges.falling;
    assign w_gap      = (i_timer_value >= LP_RESET_GAP);

    pulse_classifier #(
        .WIDTH       (WIDTH),
        .BIT1_THRESH (BIT1_THRESH),
        .MIN_HIGH    (MIN_HIGH),
        .MAX_HIGH    (MAX_HIGH)
    ) u_classifier (
        .i_high_time (i_timer_value),
        .o_bit       (w_bit),
        .o_runt      (w_runt),
        .o_overlong  (w_overlong)
    );

    // Next-state decode plus the per-cycle bit-accept and gap-detect strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_take_bit      = 1'b0;
        w_frame_end_nxt = 1'b0;
        case (r_state)
            S_SYNC: begin
                // Timer only reflects low time while the line is known low.
                if (!r_line_high && !w_any_edge && w_gap)
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_rise)
                    w_state_nxt = S_HIGH;
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_state_nxt = S_LOW;
                    w_take_bit  = ~(w_runt | w_overlong);
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    w_state_nxt = S_HIGH;
                end else if (!w_any_edge && w_gap) begin
                    w_state_nxt     = S_IDLE;
                    w_frame_end_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase
    end

    assign w_word   = {r_shift, w_bit};
    assign w_load   = w_take_bit && (r_bit_cnt == LP_LAST_BIT);
    assign w_accept = r_data_valid && i_data_ready;

    // State register, line level tracker and registered frame_end pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_SYNC;
            r_line_high <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_end <= w_frame_end_nxt;
            if (w_rise)
                r_line_high <= 1'b1;
            else if (w_fall)
                r_line_high <= 1'b0;
        end
    end

    // Partial-word shift register and bit counter; cleared on word or gap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_frame_end_nxt || w_load) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_take_bit) begin
            r_shift   <= w_word[DATA_BITS-2:0];
            r_bit_cnt <= r_bit_cnt + CW'(1);
        end
    end

    // Output holding register; a word arriving against a stalled one is dropped.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_load) begin
            if (r_data_valid && !i_data_ready) begin
                r_overflow <= 1'b1;
            end else begin
                r_data       <= w_word;
                r_data_valid <= 1'b1;
            end
        end else if (w_accept) begin
            r_data_valid <= 1'b0;
        end
    end

`ifdef PULSE_DECODER_ERRCNT_EN
    logic        w_bad_pulse;
    logic [15:0] r_err_count;

    assign w_bad_pulse = (r_state == S_HIGH) && w_fall && (w_runt || w_overlong);

    // Saturating count of discarded runt/overlong pulses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_err_count <= '0;
        else if (w_bad_pulse && (r_err_count != 16'hFFFF))
            r_err_count <= r_err_count + 16'd1;
    end

    assign o_err_count = r_err_count;
`else
    assign o_err_count = '0;
`endif

    assign o_data       = r_data;
    assign o_data_valid = r_data_valid;
    assign o_frame_end  = r_frame_end;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_pulse_decoder.sv
// Self-checking bench for pulse_decoder (DATA_BITS=24, default thresholds).
// Drives the line as pulse/low sequences through a behavioural timer and
// compares against a pulse-level reference model.
module tb_pulse_decoder;
    import pipeline_types::*;

    localparam int WIDTH = 12;
    localparam int DB    = 24;
    localparam int RC    = 2500;

    logic          clk = 1'b0;
    logic          rst_n;
    edges_t        edges;
    logic [11:0]   tval;
    logic [23:0]   data;
    logic          valid;
    logic          ready;
    logic          fend;
    logic          ovf;
    logic [15:0]   errc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (pulse level, not cycle level)
    int          tcnt;
    bit          m_synced;
    bit          m_after;
    logic [23:0] m_acc;
    int          m_nbits;
    bit          m_pending;
    bit          m_ovf;
    int          m_err;
    int          m_fend;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    int          fend_pulses;
    int          fend_hi;
    bit          fend_prev;

    pulse_decoder #(
        .WIDTH        (WIDTH),
        .DATA_BITS    (DB),
        .BIT1_THRESH  (30),
        .MIN_HIGH     (8),
        .MAX_HIGH     (60),
        .RESET_CYCLES (RC)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_edges       (edges),
        .i_timer_value (tval),
        .o_data        (data),
        .o_data_valid  (valid),
        .i_data_ready  (ready),
        .o_frame_end   (fend),
        .o_overflow    (ovf),
        .o_err_count   (errc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_err();
`ifdef PULSE_DECODER_ERRCNT_EN
        return m_err;
`else
        return 0;
`endif
    endfunction

    // Monitor: record accepted words and frame_end activity.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) got_q.push_back(data);
            if (fend) fend_hi++;
            if (fend && !fend_prev) fend_pulses++;
            fend_prev = fend;
        end else begin
            fend_prev = 1'b0;
        end
    end

    // One clock of stimulus with a behavioural saturating since-last-edge timer.
    task automatic cycle(input logic r, input logic f);
        edges.rising  = r;
        edges.falling = f;
        tval          = 12'(tcnt);
        if (r || f) tcnt = 1;
        else if (tcnt < 4095) tcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_synced  = 0;
        m_after   = 0;
        m_acc     = '0;
        m_nbits   = 0;
        m_pending = 0;
        m_ovf     = 0;
        m_err     = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        edges = '0;
        tval  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tcnt  = 0;
        rst_n = 1'b1;
    endtask

    // High pulse of h cycles; model is updated after the falling strobe cycle.
    task automatic pulse(input int h);
        logic [23:0] word;
        cycle(1'b1, 1'b0);
        repeat (h - 1) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        if (m_synced) begin
            m_after = 1;
            if (h < 8 || h > 60) begin
                if (m_err < 65535) m_err++;
            end else begin
                m_acc = {m_acc[22:0], (h >= 30) ? 1'b1 : 1'b0};
                m_nbits++;
                if (m_nbits == DB) begin
                    m_nbits = 0;
                    word    = m_acc;
                    if (m_pending) begin
                        m_ovf = 1;
                        check_eq("ovf_set", {31'd0, ovf}, 32'd1);
                        check_eq("ovf_hold_data", {8'd0, data}, {8'd0, exp_q[$]});
                    end else begin
                        exp_q.push_back(word);
                        check_eq("word_valid_lat1", {31'd0, valid}, 32'd1);
                        check_eq("word_data", {8'd0, data}, {8'd0, word});
                        if (!ready) m_pending = 1;
                    end
                end
            end
        end
    endtask

    task automatic low(input int l);
        repeat (l - 1) cycle(1'b0, 1'b0);
    endtask

    // Long low stretch; >= RC means a frame-reset gap.
    task automatic gap(input int n);
        repeat (n) cycle(1'b0, 1'b0);
        if (n >= RC + 1) begin
            if (!m_synced) begin
                m_synced = 1;
            end else if (m_after) begin
                m_fend++;
                m_nbits = 0;
                m_acc   = '0;
                m_after = 0;
            end
        end
        check_eq("frame_end_count", fend_pulses, m_fend);
        check_eq("frame_end_width", fend_hi, fend_pulses);
    endtask

    function automatic int rand_high(input bit b);
        int pick;
        pick = int'($urandom_range(0, 3));
        if (pick == 0) return b ? ((($urandom_range(0, 1)) != 0) ? 30 : 60)
                                : ((($urandom_range(0, 1)) != 0) ? 8 : 29);
        return b ? int'($urandom_range(30, 60)) : int'($urandom_range(8, 29));
    endfunction

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) begin
            pulse(rand_high(1'($urandom_range(0, 1))));
            low(int'($urandom_range(8, 60)));
        end
    endtask

    initial begin
        edges = '0;
        tval  = '0;
        ready = 1'b1;
        tcnt  = 0;
        m_fend = 0;
        fend_pulses = 0;
        fend_hi = 0;
        fend_prev = 0;
        apply_reset();

        // 1: reset exit, first gap gives no frame_end
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        gap(RC + 10);
        check_eq("sync_data", {8'd0, data}, 32'd0);
        check_eq("sync_valid", {31'd0, valid}, 32'd0);
        check_eq("sync_ovf", {31'd0, ovf}, 32'd0);
        check_eq("sync_err", {16'd0, errc}, 32'd0);

        // 2: alternating 40/20 -> AAAAAA, 1-cycle latency
        for (int i = 0; i < DB; i++) begin
            if (i == DB - 1) check_eq("no_early_valid", {31'd0, valid}, 32'd0);
            pulse((i % 2 == 0) ? 40 : 20);
            if (i == DB - 1) check_eq("word_aaaaaa", {8'd0, data}, 32'h00AAAAAA);
            low(25);
        end

        // 3: backpressure, second word dropped, one transfer after ready
        ready = 1'b0;
        send_random(2 * DB);
        check_eq("bp_valid", {31'd0, valid}, 32'd1);
        check_eq("bp_ovf", {31'd0, ovf}, {31'd0, m_ovf});
        check_eq("bp_no_transfer", got_q.size(), exp_q.size() - 1);
        ready = 1'b1;
        m_pending = 0;
        repeat (3) cycle(1'b0, 1'b0);
        check_eq("bp_one_transfer", got_q.size(), exp_q.size());
        check_eq("bp_valid_drop", {31'd0, valid}, 32'd0);
        check_eq("bp_ovf_sticky", {31'd0, ovf}, 32'd1);

        // 4: partial frame then reset gap, then a clean word
        send_random(10);
        gap(RC + 10);
        check_eq("partial_no_valid", {31'd0, valid}, 32'd0);
        send_random(DB);

        // 5: runt and overlong inside a word
        send_random(10);
        pulse(5);
        low(30);
        send_random(7);
        pulse(70);
        low(30);
        send_random(7);
        check_eq("err_count", {16'd0, errc}, exp_err());

        // 6: reset after 12 bits; outputs clear at once, resync needed
        send_random(12);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_data", {8'd0, data}, 32'd0);
        check_eq("midrst_ovf", {31'd0, ovf}, 32'd0);
        check_eq("midrst_err", {16'd0, errc}, 32'd0);
        check_eq("midrst_valid", {31'd0, valid}, 32'd0);
        apply_reset();
        send_random(DB);
        check_eq("unsynced_no_valid", {31'd0, valid}, 32'd0);
        gap(RC + 10);
        send_random(DB);

        // Random frames of random length
        for (int k = 0; k < 3; k++) begin
            send_random(int'($urandom_range(0, 40)));
            gap(RC + 10);
        end

        repeat (3) cycle(1'b0, 1'b0);
        check_eq("total_words", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq("word_stream", {8'd0, got_q[i]}, {8'd0, exp_q[i]});
        check_eq("final_err", {16'd0, errc}, exp_err());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
